// File: rtl/rob_superscalar.sv
// rob_superscalar: parametrised multi-issue reorder buffer.
//
// Sits between dispatch, the CDB broadcast network, the load/store unit and
// the architectural register file / store commit path. Entries are allocated
// in order up to ALLOC_WIDTH per cycle, and results arrive on CDB_PORTS
// broadcast ports. Entries retire in order up to COMMIT_WIDTH per cycle, with
// at most one store per cycle.
//
// Optional feature: define ROB_FLUSH_EN to add the flush/flush_tag squash
// inputs. Without it those ports and the squash logic are absent.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   alloc_*               per-lane allocate request group (lanes contiguous)
//   alloc_tag             tag assigned to each lane (tail + lane)
//   full, empty, count    occupancy status derived from head/tail pointers
//   cdb_*                 result broadcast ports (value, or address for stores)
//   read_tag/value/ready  operand read of a single entry (no CDB bypass)
//   load_address/tag      load disambiguation query -> pending_stores
//   store_commit_ready    memory accepts a store this cycle
//   commit_*              per-lane retirement outputs
module rob_superscalar #(
  parameter int ROB_SIZE     = 8,
  parameter int ALLOC_WIDTH  = 2,
  parameter int COMMIT_WIDTH = 2,
  parameter int CDB_PORTS    = 2,
  parameter int XLEN         = 32,
  parameter int TAG_LEN      = $clog2(ROB_SIZE)
) (
  input  logic                          clock,
  input  logic                          reset,
`ifdef ROB_FLUSH_EN
  input  logic                          flush,
  input  logic [TAG_LEN-1:0]            flush_tag,
`endif
  input  logic [ALLOC_WIDTH-1:0]        alloc_valid,
  input  logic [ALLOC_WIDTH-1:0]        alloc_wr_mem,
  input  logic [ALLOC_WIDTH*5-1:0]      alloc_dest_reg,
  input  logic [ALLOC_WIDTH*XLEN-1:0]   alloc_value_in,
  input  logic [ALLOC_WIDTH-1:0]        alloc_value_in_valid,
  input  logic [ALLOC_WIDTH*TAG_LEN-1:0] alloc_store_dep,
  output logic [ALLOC_WIDTH*TAG_LEN-1:0] alloc_tag,
  output logic                          full,
  output logic                          empty,
  output logic [TAG_LEN:0]              count,
  input  logic [CDB_PORTS-1:0]          cdb_valid,
  input  logic [CDB_PORTS*TAG_LEN-1:0]  cdb_tag,
  input  logic [CDB_PORTS*XLEN-1:0]     cdb_value,
  input  logic [TAG_LEN-1:0]            read_tag,
  output logic [XLEN-1:0]               read_value,
  output logic                          read_ready,
  input  logic [XLEN-1:0]               load_address,
  input  logic [TAG_LEN-1:0]            load_tag,
  output logic                          pending_stores,
  input  logic                          store_commit_ready,
  output logic [COMMIT_WIDTH-1:0]       commit_valid,
  output logic [COMMIT_WIDTH-1:0]       commit_wr_mem,
  output logic [COMMIT_WIDTH*5-1:0]     commit_dest_reg,
  output logic [COMMIT_WIDTH*XLEN-1:0]  commit_value,
  output logic [COMMIT_WIDTH*XLEN-1:0]  commit_addr
);

  localparam int PTR_LEN = TAG_LEN + 1;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PTR_LEN-1:0] head, tail;
  logic [TAG_LEN-1:0] head_tag, tail_tag;

  // Entry storage
  logic [ROB_SIZE-1:0] valid, value_ready, address_ready, wr_mem;
  logic [4:0]          dest_reg   [ROB_SIZE];
  logic [XLEN-1:0]     value      [ROB_SIZE];
  logic [XLEN-1:0]     dest_addr  [ROB_SIZE];
  logic [TAG_LEN-1:0]  store_dep  [ROB_SIZE];

  // Derived combinational state
  logic [PTR_LEN-1:0]  occupancy;
  logic [PTR_LEN:0]    free_slots;
  logic [TAG_LEN-1:0]  entry_rel  [ROB_SIZE];
  logic [ROB_SIZE-1:0] self_hit, dep_hit, squash;
  logic [XLEN-1:0]     self_val   [ROB_SIZE];
  logic [XLEN-1:0]     dep_val    [ROB_SIZE];
  logic [TAG_LEN-1:0]  lane_tag   [ALLOC_WIDTH];
  logic [TAG_LEN-1:0]  lane_dep   [ALLOC_WIDTH];
  logic [ALLOC_WIDTH-1:0] lane_value_ok;
  logic [XLEN-1:0]     lane_value [ALLOC_WIDTH];
  logic                alloc_fire, alloc_block;
  logic [PTR_LEN-1:0]  alloc_count, commit_count;
  logic [TAG_LEN-1:0]  commit_idx [COMMIT_WIDTH];
  logic                commit_chain, store_taken, lane_ok;
  logic [TAG_LEN-1:0]  load_rel;
  logic [PTR_LEN-1:0]  flush_tail;

  assign head_tag   = head[TAG_LEN-1:0];
  assign tail_tag   = tail[TAG_LEN-1:0];
  assign occupancy  = tail - head;
  assign free_slots = (PTR_LEN+1)'(ROB_SIZE) - {1'b0, occupancy};
  assign full       = free_slots < (PTR_LEN+1)'(ALLOC_WIDTH);
  assign empty      = (occupancy == '0);
  assign count      = occupancy;
  assign read_value = value[read_tag];
  assign read_ready = value_ready[read_tag];

`ifdef ROB_FLUSH_EN
  logic [TAG_LEN-1:0] flush_rel;
  assign flush_rel   = flush_tag - head_tag;
  assign flush_tail  = head + PTR_LEN'(flush_rel) + PTR_LEN'(1);
  assign alloc_block = flush;
  // Everything younger than flush_tag (by distance from head) is squashed.
  always_comb begin
    for (int e = 0; e < ROB_SIZE; e++) squash[e] = flush && (entry_rel[e] > flush_rel);
  end
`else
  assign flush_tail  = tail;
  assign alloc_block = 1'b0;
  assign squash      = '0;
`endif

  // Age of each slot measured from head; smaller means older.
  always_comb begin
    for (int e = 0; e < ROB_SIZE; e++) entry_rel[e] = TAG_LEN'(e) - head_tag;
  end

  // Per-entry CDB match. Ports are scanned high to low so port 0 wins a tie.
  always_comb begin
    for (int e = 0; e < ROB_SIZE; e++) begin
      self_hit[e] = 1'b0;
      self_val[e] = '0;
      dep_hit[e]  = 1'b0;
      dep_val[e]  = '0;
      for (int p = CDB_PORTS - 1; p >= 0; p--) begin
        if (cdb_valid[p] && cdb_tag[p*TAG_LEN +: TAG_LEN] == TAG_LEN'(e)) begin
          self_hit[e] = 1'b1;
          self_val[e] = cdb_value[p*XLEN +: XLEN];
        end
        if (cdb_valid[p] && cdb_tag[p*TAG_LEN +: TAG_LEN] == store_dep[e]) begin
          dep_hit[e] = 1'b1;
          dep_val[e] = cdb_value[p*XLEN +: XLEN];
        end
      end
    end
  end

  // Allocate lane tags, group size and store-value capture at allocate time.
  // A dependency on an earlier lane of the same group cannot be resolved yet,
  // so that lane always waits even if a stale CDB tag happens to match.
  always_comb begin
    alloc_fire  = !full && !alloc_block;
    alloc_count = '0;
    alloc_tag   = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      lane_tag[i] = tail_tag + TAG_LEN'(i);
      lane_dep[i] = alloc_store_dep[i*TAG_LEN +: TAG_LEN];
      alloc_tag[i*TAG_LEN +: TAG_LEN] = lane_tag[i];
      alloc_count = alloc_count + PTR_LEN'(alloc_valid[i]);
    end
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      lane_value_ok[i] = 1'b0;
      lane_value[i]    = '0;
      if (alloc_wr_mem[i]) begin
        if (alloc_value_in_valid[i]) begin
          lane_value_ok[i] = 1'b1;
          lane_value[i]    = alloc_value_in[i*XLEN +: XLEN];
        end else begin
          lane_value_ok[i] = 1'b1;
          for (int j = 0; j < i; j++) begin
            if (alloc_valid[j] && lane_tag[j] == lane_dep[i]) lane_value_ok[i] = 1'b0;
          end
          if (lane_value_ok[i]) begin
            lane_value_ok[i] = 1'b0;
            for (int p = CDB_PORTS - 1; p >= 0; p--) begin
              if (cdb_valid[p] && cdb_tag[p*TAG_LEN +: TAG_LEN] == lane_dep[i]) begin
                lane_value_ok[i] = 1'b1;
                lane_value[i]    = cdb_value[p*XLEN +: XLEN];
              end
            end
            if (!lane_value_ok[i] && valid[lane_dep[i]] && value_ready[lane_dep[i]]) begin
              lane_value_ok[i] = 1'b1;
              lane_value[i]    = value[lane_dep[i]];
            end
          end
        end
      end
    end
  end

  // In-order commit selection. The first lane that cannot retire stops all
  // younger lanes; only one store may retire per cycle.
  always_comb begin
    commit_valid    = '0;
    commit_wr_mem   = '0;
    commit_dest_reg = '0;
    commit_value    = '0;
    commit_addr     = '0;
    commit_count    = '0;
    commit_chain    = 1'b1;
    store_taken     = 1'b0;
    lane_ok         = 1'b0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      commit_idx[i] = head_tag + TAG_LEN'(i);
      commit_wr_mem[i] = wr_mem[commit_idx[i]];
      commit_dest_reg[i*5 +: 5]     = dest_reg[commit_idx[i]];
      commit_value[i*XLEN +: XLEN]  = value[commit_idx[i]];
      commit_addr[i*XLEN +: XLEN]   = dest_addr[commit_idx[i]];
      lane_ok = valid[commit_idx[i]] && value_ready[commit_idx[i]] &&
                (!wr_mem[commit_idx[i]] || address_ready[commit_idx[i]]);
      if (wr_mem[commit_idx[i]]) lane_ok = lane_ok && store_commit_ready && !store_taken;
      if (commit_chain && lane_ok) begin
        commit_valid[i] = 1'b1;
        commit_count    = commit_count + PTR_LEN'(1);
        if (wr_mem[commit_idx[i]]) store_taken = 1'b1;
      end else begin
        commit_chain = 1'b0;
      end
    end
  end

  // A load is blocked by any strictly older store whose address is unknown
  // or equals the load address.
  always_comb begin
    load_rel       = load_tag - head_tag;
    pending_stores = 1'b0;
    for (int e = 0; e < ROB_SIZE; e++) begin
      if (entry_rel[e] < load_rel && valid[e] && wr_mem[e] &&
          (!address_ready[e] || dest_addr[e] == load_address))
        pending_stores = 1'b1;
    end
  end

  // State update: CDB writes first, then retirement/squash invalidation,
  // then new allocations. Allocated slots are always free slots, so they
  // never collide with a CDB write or a retiring entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head          <= '0;
      tail          <= '0;
      valid         <= '0;
      value_ready   <= '0;
      address_ready <= '0;
      wr_mem        <= '0;
      for (int e = 0; e < ROB_SIZE; e++) begin
        dest_reg[e]  <= '0;
        value[e]     <= '0;
        dest_addr[e] <= '0;
        store_dep[e] <= '0;
      end
    end else begin
      for (int e = 0; e < ROB_SIZE; e++) begin
        if (valid[e] && !squash[e]) begin
          if (self_hit[e]) begin
            if (wr_mem[e]) begin
              dest_addr[e]     <= self_val[e];
              address_ready[e] <= 1'b1;
            end else begin
              value[e]       <= self_val[e];
              value_ready[e] <= 1'b1;
            end
          end
          if (wr_mem[e] && !value_ready[e] && dep_hit[e]) begin
            value[e]       <= dep_val[e];
            value_ready[e] <= 1'b1;
          end
        end
      end
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (commit_valid[i]) valid[commit_idx[i]] <= 1'b0;
      end
      for (int e = 0; e < ROB_SIZE; e++) begin
        if (squash[e]) valid[e] <= 1'b0;
      end
      if (alloc_fire) begin
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
          if (alloc_valid[i]) begin
            valid[lane_tag[i]]         <= 1'b1;
            wr_mem[lane_tag[i]]        <= alloc_wr_mem[i];
            dest_reg[lane_tag[i]]      <= alloc_dest_reg[i*5 +: 5];
            store_dep[lane_tag[i]]     <= lane_dep[i];
            address_ready[lane_tag[i]] <= 1'b0;
            dest_addr[lane_tag[i]]     <= '0;
            value_ready[lane_tag[i]]   <= lane_value_ok[i];
            value[lane_tag[i]]         <= lane_value[i];
          end
        end
      end
      head <= head + commit_count;
      if (alloc_block) tail <= flush_tail;
      else if (alloc_fire) tail <= tail + alloc_count;
    end
  end

endmodule

// File: tb/tb_rob_superscalar.sv
// tb_rob_superscalar: directed self-checking bench for rob_superscalar.
// Retirements are checked against a queue of expected commit records that is
// filled when the results making those entries ready are driven.
module tb_rob_superscalar;

  localparam int TL = 3;
  localparam int XL = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    alloc_valid, alloc_wr_mem, alloc_value_in_valid;
  logic [9:0]    alloc_dest_reg;
  logic [63:0]   alloc_value_in;
  logic [5:0]    alloc_store_dep, alloc_tag;
  logic          full, empty;
  logic [3:0]    count;
  logic [1:0]    cdb_valid;
  logic [5:0]    cdb_tag;
  logic [63:0]   cdb_value;
  logic [2:0]    read_tag, load_tag;
  logic [31:0]   read_value, load_address;
  logic          read_ready, pending_stores, store_commit_ready;
  logic [1:0]    commit_valid, commit_wr_mem;
  logic [9:0]    commit_dest_reg;
  logic [63:0]   commit_value, commit_addr;
`ifdef ROB_FLUSH_EN
  logic          flush;
  logic [2:0]    flush_tag;
`endif

  rob_superscalar dut (
    .clock(clock), .reset(reset),
`ifdef ROB_FLUSH_EN
    .flush(flush), .flush_tag(flush_tag),
`endif
    .alloc_valid(alloc_valid), .alloc_wr_mem(alloc_wr_mem),
    .alloc_dest_reg(alloc_dest_reg), .alloc_value_in(alloc_value_in),
    .alloc_value_in_valid(alloc_value_in_valid), .alloc_store_dep(alloc_store_dep),
    .alloc_tag(alloc_tag), .full(full), .empty(empty), .count(count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .read_tag(read_tag), .read_value(read_value), .read_ready(read_ready),
    .load_address(load_address), .load_tag(load_tag), .pending_stores(pending_stores),
    .store_commit_ready(store_commit_ready), .commit_valid(commit_valid),
    .commit_wr_mem(commit_wr_mem), .commit_dest_reg(commit_dest_reg),
    .commit_value(commit_value), .commit_addr(commit_addr)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        wr_mem;
    logic [4:0]  dest;
    logic [31:0] value;
    logic [31:0] addr;
  } commit_t;

  commit_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_commit(input logic wr, input logic [4:0] dest,
                               input logic [31:0] val, input logic [31:0] addr);
    commit_t e;
    e.wr_mem = wr; e.dest = dest; e.value = val; e.addr = addr;
    sb.push_back(e);
  endtask

  task automatic check_commit(input string tag, input logic [1:0] exp_valid);
    check({tag, "_valid"}, commit_valid, exp_valid);
    for (int i = 0; i < 2; i++) begin
      if (commit_valid[i]) begin
        if (sb.size() == 0) begin
          check({tag, "_sb_depth"}, sb.size(), 1);
        end else begin
          commit_t e;
          e = sb.pop_front();
          check({tag, "_wr_mem"}, commit_wr_mem[i], e.wr_mem);
          check({tag, "_dest"},   commit_dest_reg[i*5 +: 5], e.dest);
          check({tag, "_value"},  commit_value[i*XL +: XL], e.value);
          check({tag, "_addr"},   commit_addr[i*XL +: XL], e.addr);
        end
      end
    end
  endtask

  task automatic clear_drive();
    alloc_valid = '0; alloc_wr_mem = '0; alloc_dest_reg = '0;
    alloc_value_in = '0; alloc_value_in_valid = '0; alloc_store_dep = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
`ifdef ROB_FLUSH_EN
    flush = 1'b0; flush_tag = '0;
`endif
  endtask

  task automatic drive_alloc(input int lane, input logic wr, input logic [4:0] dest,
                             input logic vin_valid, input logic [31:0] vin, input logic [2:0] dep);
    alloc_valid[lane] = 1'b1;
    alloc_wr_mem[lane] = wr;
    alloc_dest_reg[lane*5 +: 5] = dest;
    alloc_value_in_valid[lane] = vin_valid;
    alloc_value_in[lane*XL +: XL] = vin;
    alloc_store_dep[lane*TL +: TL] = dep;
  endtask

  task automatic drive_cdb(input int port, input logic [2:0] tag, input logic [31:0] val);
    cdb_valid[port] = 1'b1;
    cdb_tag[port*TL +: TL] = tag;
    cdb_value[port*XL +: XL] = val;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
    clear_drive();
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clear_drive();
    store_commit_ready = 1'b0;
    read_tag = '0; load_tag = '0; load_address = '0;

    // Reset state
    sample();
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_count", count, 4'd0);
    check("rst_commit", commit_valid, 2'b00);
    check("rst_pending", pending_stores, 1'b0);
    check("rst_alloc_tag", alloc_tag, {3'd1, 3'd0});
    check("rst_read_ready", read_ready, 1'b0);
    check("rst_read_value", read_value, 32'd0);
    reset = 1'b1;
    next_cycle();

    // Two-lane allocate, then two CDB ports in one cycle, then dual commit
    drive_alloc(0, 1'b0, 5'd3, 1'b0, 32'd0, 3'd0);
    drive_alloc(1, 1'b0, 5'd4, 1'b0, 32'd0, 3'd0);
    sample();
    check("t1_alloc_tag", alloc_tag, {3'd1, 3'd0});
    next_cycle();
    drive_cdb(0, 3'd1, 32'd7);
    drive_cdb(1, 3'd0, 32'd5);
    expect_commit(1'b0, 5'd3, 32'd5, 32'd0);
    expect_commit(1'b0, 5'd4, 32'd7, 32'd0);
    sample();
    check("t1_count", count, 4'd2);
    check("t1_empty", empty, 1'b0);
    check_commit("t1_pre", 2'b00);
    next_cycle();
    read_tag = 3'd1;
    sample();
    check_commit("t1_dual", 2'b11);
    check("t1_read_value", read_value, 32'd7);
    check("t1_read_ready", read_ready, 1'b1);
    next_cycle();
    sample();
    check("t1_post_count", count, 4'd0);
    check("t1_post_empty", empty, 1'b1);
    pulse_reset();
    next_cycle();

    // Fill to full, drop a group while full, free two slots, wrap tags
    for (int g = 0; g < 4; g++) begin
      drive_alloc(0, 1'b0, 5'(10 + 2*g), 1'b0, 32'd0, 3'd0);
      drive_alloc(1, 1'b0, 5'(11 + 2*g), 1'b0, 32'd0, 3'd0);
      sample();
      check("t2_fill_full", full, 1'b0);
      check("t2_fill_tag", alloc_tag, {3'(2*g + 1), 3'(2*g)});
      next_cycle();
    end
    drive_alloc(0, 1'b0, 5'd30, 1'b0, 32'd0, 3'd0);
    drive_alloc(1, 1'b0, 5'd31, 1'b0, 32'd0, 3'd0);
    drive_cdb(0, 3'd0, 32'h100);
    drive_cdb(1, 3'd1, 32'h101);
    expect_commit(1'b0, 5'd10, 32'h100, 32'd0);
    expect_commit(1'b0, 5'd11, 32'h101, 32'd0);
    sample();
    check("t2_full", full, 1'b1);
    check("t2_count8", count, 4'd8);
    check_commit("t2_none", 2'b00);
    next_cycle();
    drive_alloc(0, 1'b0, 5'd20, 1'b0, 32'd0, 3'd0);
    drive_alloc(1, 1'b0, 5'd21, 1'b0, 32'd0, 3'd0);
    sample();
    check("t2_dropped_count", count, 4'd8);
    check("t2_still_full", full, 1'b1);
    check_commit("t2_head", 2'b11);
    next_cycle();
    drive_alloc(0, 1'b0, 5'd20, 1'b0, 32'd0, 3'd0);
    drive_alloc(1, 1'b0, 5'd21, 1'b0, 32'd0, 3'd0);
    sample();
    check("t2_freed_count", count, 4'd6);
    check("t2_freed_full", full, 1'b0);
    check("t2_wrap_tag", alloc_tag, {3'd1, 3'd0});
    check_commit("t2_after", 2'b00);
    next_cycle();
    sample();
    check("t2_refill_count", count, 4'd8);
    check("t2_refill_full", full, 1'b1);
    reset = 1'b0;
    #1;
    check("t2_async_count", count, 4'd0);
    check("t2_async_empty", empty, 1'b1);
    check("t2_async_commit", commit_valid, 2'b00);
    reset = 1'b1;
    next_cycle();

    // Store value captured from a same-cycle CDB match on its dependency
    drive_alloc(0, 1'b0, 5'd5, 1'b0, 32'd0, 3'd0);
    next_cycle();
    drive_alloc(0, 1'b1, 5'd0, 1'b0, 32'd0, 3'd0);
    drive_cdb(0, 3'd0, 32'd9);
    expect_commit(1'b0, 5'd5, 32'd9, 32'd0);
    sample();
    check("t3_store_tag", alloc_tag[2:0], 3'd1);
    next_cycle();
    read_tag = 3'd1;
    drive_cdb(0, 3'd1, 32'h40);
    expect_commit(1'b1, 5'd0, 32'd9, 32'h40);
    store_commit_ready = 1'b1;
    sample();
    check_commit("t3_alu", 2'b01);
    check("t3_store_ready", read_ready, 1'b1);
    check("t3_store_value", read_value, 32'd9);
    next_cycle();
    sample();
    check_commit("t3_store", 2'b01);
    next_cycle();
    sample();
    check("t3_empty", empty, 1'b1);
    store_commit_ready = 1'b0;
    next_cycle();

    // Same-group dependency waits; copy from ready entry; one store per cycle
    drive_alloc(0, 1'b0, 5'd7, 1'b0, 32'd0, 3'd0);
    drive_alloc(1, 1'b1, 5'd0, 1'b0, 32'd0, 3'd2);
    drive_cdb(0, 3'd2, 32'h55);
    sample();
    check("t4_alloc_tag", alloc_tag, {3'd3, 3'd2});
    next_cycle();
    drive_cdb(0, 3'd2, 32'h66);
    expect_commit(1'b0, 5'd7, 32'h66, 32'd0);
    read_tag = 3'd3;
    sample();
    check("t4_group_wait", read_ready, 1'b0);
    read_tag = 3'd2;
    #1;
    check("t4_cdb_invalid_ignored", read_ready, 1'b0);
    next_cycle();
    read_tag = 3'd3;
    drive_alloc(0, 1'b1, 5'd0, 1'b0, 32'd0, 3'd2);
    sample();
    check_commit("t4_alu", 2'b01);
    check("t4_dep_cdb_ready", read_ready, 1'b1);
    check("t4_dep_cdb_value", read_value, 32'h66);
    check("t4_store2_tag", alloc_tag[2:0], 3'd4);
    next_cycle();
    drive_cdb(0, 3'd3, 32'h100);
    drive_cdb(1, 3'd4, 32'h104);
    expect_commit(1'b1, 5'd0, 32'h66, 32'h100);
    expect_commit(1'b1, 5'd0, 32'h66, 32'h104);
    read_tag = 3'd4;
    sample();
    check_commit("t4_noaddr", 2'b00);
    check("t4_copy_ready", read_ready, 1'b1);
    check("t4_copy_value", read_value, 32'h66);
    next_cycle();
    sample();
    check_commit("t4_mem_busy", 2'b00);
    check("t4_count", count, 4'd2);
    store_commit_ready = 1'b1;
    #1;
    check_commit("t4_store_a", 2'b01);
    next_cycle();
    sample();
    check_commit("t4_store_b", 2'b01);
    next_cycle();
    sample();
    check("t4_empty", empty, 1'b1);
    store_commit_ready = 1'b0;
    pulse_reset();
    next_cycle();

    // Pending-store check for loads
    drive_alloc(0, 1'b0, 5'd1, 1'b0, 32'd0, 3'd0);
    drive_alloc(1, 1'b1, 5'd0, 1'b1, 32'h11, 3'd0);
    next_cycle();
    drive_alloc(0, 1'b1, 5'd0, 1'b1, 32'h22, 3'd0);
    drive_alloc(1, 1'b0, 5'd2, 1'b0, 32'd0, 3'd0);
    next_cycle();
    drive_cdb(0, 3'd1, 32'd5);
    next_cycle();
    load_tag = 3'd3;
    load_address = 32'd4;
    drive_cdb(0, 3'd2, 32'd8);
    sample();
    check("t5_unknown_addr", pending_stores, 1'b1);
    load_tag = 3'd1;
    #1;
    check("t5_only_alu_older", pending_stores, 1'b0);
    load_tag = 3'd0;
    #1;
    check("t5_head_load", pending_stores, 1'b0);
    load_tag = 3'd3;
    next_cycle();
    sample();
    check("t5_no_conflict", pending_stores, 1'b0);
    load_address = 32'd5;
    #1;
    check("t5_addr_match", pending_stores, 1'b1);
    check_commit("t5_blocked", 2'b00);
    next_cycle();

`ifdef ROB_FLUSH_EN
    // Flush squashes younger entries and drops the same-cycle group
    pulse_reset();
    next_cycle();
    for (int g = 0; g < 3; g++) begin
      drive_alloc(0, 1'b0, 5'(2*g), 1'b0, 32'd0, 3'd0);
      drive_alloc(1, 1'b0, 5'(2*g + 1), 1'b0, 32'd0, 3'd0);
      next_cycle();
    end
    flush = 1'b1;
    flush_tag = 3'd2;
    drive_alloc(0, 1'b0, 5'd9, 1'b0, 32'd0, 3'd0);
    drive_cdb(0, 3'd4, 32'h77);
    next_cycle();
    read_tag = 3'd4;
    sample();
    check("fl_count", count, 4'd3);
    check("fl_next_tag", alloc_tag[2:0], 3'd3);
    check("fl_squashed_ready", read_ready, 1'b0);
    next_cycle();
    drive_cdb(0, 3'd4, 32'h99);
    next_cycle();
    sample();
    check("fl_cdb_ignored", read_ready, 1'b0);
    check("fl_count_hold", count, 4'd3);
`endif

    check("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
